// File: rtl/res_arbiter.sv
// Round-robin arbiter for the single res memory port, shared by the pass
// engines. A requester may lock the port for a bounded read-modify-write run.
// Read data returns one cycle after the read grant and is tagged by rvalid.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_UNLOCKED | round-robin from ptr among all requesters
// ST_LOCKED   | only owner may be granted; released on req_lock drop or
//             | after MAX_LOCK consecutive owner grants
module res_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 locked,
    output logic                 res_rd,
    output logic                 res_wr,
    output logic [AW-1:0]        res_addr,
    output logic [DW-1:0]        res_do,
    input  logic [DW-1:0]        res_di
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t         state_q, state_n;
    logic [PW-1:0]  ptr_q, ptr_n;
    logic [PW-1:0]  owner_q, owner_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic [PW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [PW:0]    cand;

    // Grant selection: owner only while locked, else first requester at or after ptr
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (state_q == ST_LOCKED) begin
            if (req[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr_q} + (PW+1)'(k);
                if (cand >= (PW+1)'(NREQ)) begin
                    cand = cand - (PW+1)'(NREQ);
                end
                if (!gnt_any && req[cand[PW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[PW-1:0];
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Memory port follows the granted requester; idle port drives all zeros
    always_comb begin
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        if (gnt_any) begin
            res_addr = req_addr[int'(gnt_idx)*AW +: AW];
            res_wr   = req_wr[gnt_idx];
            res_rd   = ~req_wr[gnt_idx];
            if (req_wr[gnt_idx]) begin
                res_do = req_wdata[int'(gnt_idx)*DW +: DW];
            end
        end
    end

    // Next pointer and lock state; a capped release still advances ptr past owner
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        if (gnt_any) begin
            ptr_n = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        case (state_q)
            ST_UNLOCKED: begin
                if (gnt_any && req_lock[gnt_idx]) begin
                    state_n = ST_LOCKED;
                    owner_n = gnt_idx;
                    cnt_n   = CW'(1);
                end
            end
            ST_LOCKED: begin
                if (!req_lock[owner_q]) begin
                    state_n = ST_UNLOCKED;
                    cnt_n   = '0;
                end else if (gnt_any) begin
                    if (cnt_q == CW'(MAX_LOCK-1)) begin
                        state_n = ST_UNLOCKED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: state_n = ST_UNLOCKED;
        endcase
    end

    // State registers; reset also drops any read return still in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_UNLOCKED;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rvalid  <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
            rvalid  <= gnt & ~req_wr;
        end
    end

    assign locked = (state_q == ST_LOCKED);
    assign rdata  = res_di;

endmodule

// File: tb/tb_res_arbiter.sv
// Bench for res_arbiter: a behavioural reference drives a per-cycle
// scoreboard of read returns, and each scenario adds its own fixed checks.
module tb_res_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 16;

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [DW-1:0]   data;
    } sb_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req, req_wr, req_lock;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [DW-1:0]        rdata;
    logic                 locked;
    logic                 res_rd, res_wr;
    logic [AW-1:0]        res_addr;
    logic [DW-1:0]        res_do;
    logic [DW-1:0]        res_di = '0;

    logic [DW-1:0]        mem  [0:(1<<AW)-1];
    logic [DW-1:0]        smem [0:(1<<AW)-1];
    bit                   mem_ready = 1'b0;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    int  m_ptr, m_owner, m_cnt;
    bit  m_locked;
    sb_t sbq[$];

    logic [NREQ-1:0] obs_gnt, obs_rvalid;
    logic [DW-1:0]   obs_rdata, obs_do;
    logic [AW-1:0]   obs_addr;
    logic            obs_locked, obs_rd, obs_wr;

    res_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .locked    (locked),
        .res_rd    (res_rd),
        .res_wr    (res_wr),
        .res_addr  (res_addr),
        .res_do    (res_do),
        .res_di    (res_di)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 'h0ABC) return 8'h5A;
        return DW'(a * 7 + 3);
    endfunction

    // Memory with one-cycle read latency; filled on the first clock edge
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= init_val(a);
            mem_ready <= 1'b1;
        end else begin
            if (res_wr) mem[res_addr] <= res_do;
            if (res_rd) res_di <= mem[res_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_winner();
        int c;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        req = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic r, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; req_wr[i] = wr; req_lock[i] = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: check outputs mid-cycle against the reference, then advance it
    task automatic cycle();
        int w;
        logic [NREQ-1:0] eg;
        logic e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_do;
        sb_t e, nx;
        @(negedge clk);
        w = exp_winner();
        eg = '0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_do = '0;
        if (w >= 0) begin
            eg[w]  = 1'b1;
            e_addr = req_addr[w*AW +: AW];
            e_wr   = req_wr[w];
            e_rd   = ~req_wr[w];
            if (req_wr[w]) e_do = req_wdata[w*DW +: DW];
        end
        obs_gnt = gnt; obs_locked = locked; obs_rvalid = rvalid; obs_rdata = rdata;
        obs_rd = res_rd; obs_wr = res_wr; obs_addr = res_addr; obs_do = res_do;
        if (sbq.size() > 0) e = sbq.pop_front();
        else begin e.rv = '0; e.data = '0; end
        if (chk_en) begin
            n_tests++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL gnt t=%0t got %b exp %b", $time, gnt, eg);
            end
            n_tests++;
            if (locked !== m_locked) begin
                n_fail++; $display("FAIL locked t=%0t got %b exp %b", $time, locked, m_locked);
            end
            n_tests++;
            if ({res_rd, res_wr, res_addr, res_do} !== {e_rd, e_wr, e_addr, e_do}) begin
                n_fail++;
                $display("FAIL mem_port t=%0t got rd=%b wr=%b addr=%h do=%h exp rd=%b wr=%b addr=%h do=%h",
                         $time, res_rd, res_wr, res_addr, res_do, e_rd, e_wr, e_addr, e_do);
            end
            n_tests++;
            if (rvalid !== e.rv) begin
                n_fail++; $display("FAIL rvalid t=%0t got %b exp %b", $time, rvalid, e.rv);
            end
            if (e.rv != '0) begin
                n_tests++;
                if (rdata !== e.data) begin
                    n_fail++; $display("FAIL rdata t=%0t got %h exp %h", $time, rdata, e.data);
                end
            end
        end
        nx.rv = '0; nx.data = '0;
        if (w >= 0 && reset && !req_wr[w]) begin
            nx.rv[w] = 1'b1;
            nx.data  = smem[e_addr];
        end
        sbq.push_back(nx);
        @(posedge clk);
        if (w >= 0 && req_wr[w]) smem[e_addr] = e_do;
        if (!reset) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0;
        end else begin
            if (w >= 0) m_ptr = (w + 1) % NREQ;
            if (m_locked) begin
                if (w >= 0) m_cnt++;
                if (!req_lock[m_owner] || m_cnt == MAX_LOCK) m_locked = 1'b0;
            end else if (w >= 0 && req_lock[w]) begin
                m_locked = 1'b1; m_owner = w; m_cnt = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear_inputs(); cycle(); reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 1'b1, 1'b0, 1'b1, 14'h0010, 8'h00);
        cycle();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 14'h0020, 8'h00);
        drive(2, 1'b1, 1'b0, 1'b0, 14'h0030, 8'h00);
        cycle();
        n_tests++;
        if (obs_locked !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_locked got %b exp 1", obs_locked);
        end
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(i + 64), 8'h00);
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b000) begin
            n_fail++; $display("FAIL reset_rvalid got %b exp 000", obs_rvalid);
        end
        n_tests++;
        if (obs_locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_locked got %b exp 0", obs_locked);
        end
        n_tests++;
        if (obs_gnt !== 3'b001) begin
            n_fail++; $display("FAIL reset_first_gnt got %b exp 001", obs_gnt);
        end
        clear_inputs();
        cycle();
    endtask

    task automatic test_single_read();
        clear_inputs();
        drive(1, 1'b1, 1'b0, 1'b0, 14'h0ABC, 8'h00);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b010 || obs_rd !== 1'b1 || obs_addr !== 14'h0ABC) begin
            n_fail++;
            $display("FAIL single_issue got gnt=%b rd=%b addr=%h exp gnt=010 rd=1 addr=0abc",
                     obs_gnt, obs_rd, obs_addr);
        end
        clear_inputs();
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b010 || obs_rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_return got rvalid=%b rdata=%h exp rvalid=010 rdata=5a",
                     obs_rvalid, obs_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] eg;
        do_reset();
        for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(i * 16 + 1), 8'h00);
        for (int k = 0; k < 6; k++) begin
            cycle();
            eg = 3'b001 << (k % 3);
            n_tests++;
            if (obs_gnt !== eg) begin
                n_fail++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, obs_gnt, eg);
            end
            if (k > 0) begin
                eg = 3'b001 << ((k - 1) % 3);
                n_tests++;
                if (obs_rvalid !== eg) begin
                    n_fail++; $display("FAIL rr_rvalid k=%0d got %b exp %b", k, obs_rvalid, eg);
                end
            end
        end
        clear_inputs();
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b100) begin
            n_fail++; $display("FAIL rr_last_rvalid got %b exp 100", obs_rvalid);
        end
    endtask

    task automatic test_lock_rmw();
        do_reset();
        drive(1, 1'b1, 1'b0, 1'b0, 14'd7, 8'h00);
        cycle();
        clear_inputs();
        drive(0, 1'b1, 1'b0, 1'b0, 14'd5, 8'h00);
        drive(2, 1'b1, 1'b0, 1'b1, 14'd130, 8'h00);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b100) begin
            n_fail++; $display("FAIL rmw_read_gnt got %b exp 100", obs_gnt);
        end
        drive(2, 1'b1, 1'b1, 1'b0, 14'd130, 8'd7);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b100 || obs_locked !== 1'b1 || obs_wr !== 1'b1 || obs_do !== 8'd7) begin
            n_fail++;
            $display("FAIL rmw_write got gnt=%b locked=%b wr=%b do=%h exp gnt=100 locked=1 wr=1 do=07",
                     obs_gnt, obs_locked, obs_wr, obs_do);
        end
        drive(2, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b001 || obs_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_after got gnt=%b locked=%b exp gnt=001 locked=0", obs_gnt, obs_locked);
        end
        clear_inputs();
        drive(1, 1'b1, 1'b0, 1'b0, 14'd130, 8'h00);
        cycle();
        clear_inputs();
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b010 || obs_rdata !== 8'd7) begin
            n_fail++;
            $display("FAIL rmw_readback got rvalid=%b rdata=%h exp rvalid=010 rdata=07", obs_rvalid, obs_rdata);
        end
    endtask

    task automatic test_lock_cap();
        logic [NREQ-1:0] eg;
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b1, 14'd40, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 14'd41, 8'h00);
        for (int k = 0; k < 40; k++) begin
            cycle();
            eg = ((k % 17) < 16) ? 3'b001 : 3'b010;
            n_tests++;
            if (obs_gnt !== eg) begin
                n_fail++; $display("FAIL cap_gnt k=%0d got %b exp %b", k, obs_gnt, eg);
            end
            if (k == 15 || k == 16 || k == 18) begin
                n_tests++;
                if (obs_locked !== (k != 16)) begin
                    n_fail++; $display("FAIL cap_locked k=%0d got %b exp %b", k, obs_locked, k != 16);
                end
            end
        end
        clear_inputs();
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 1'b1, 1'b0, 1'b1, 14'd300, 8'h00);
        cycle();
        reset = 1'b0;
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b010 || obs_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_during got gnt=%b locked=%b exp gnt=010 locked=1", obs_gnt, obs_locked);
        end
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 14'd301, 8'h00);
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b000 || obs_locked !== 1'b0 || obs_gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_after got rvalid=%b locked=%b gnt=%b exp rvalid=000 locked=0 gnt=001",
                     obs_rvalid, obs_locked, obs_gnt);
        end
        clear_inputs();
        cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 14'd200, 8'h33);
        drive(1, 1'b1, 1'b0, 1'b0, 14'd200, 8'h00);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b001 || obs_wr !== 1'b1) begin
            n_fail++; $display("FAIL b2b_write got gnt=%b wr=%b exp gnt=001 wr=1", obs_gnt, obs_wr);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 14'd0, 8'h00);
        cycle();
        n_tests++;
        if (obs_gnt !== 3'b010) begin
            n_fail++; $display("FAIL b2b_read got gnt=%b exp 010", obs_gnt);
        end
        clear_inputs();
        cycle();
        n_tests++;
        if (obs_rvalid !== 3'b010 || obs_rdata !== 8'h33) begin
            n_fail++;
            $display("FAIL b2b_return got rvalid=%b rdata=%h exp rvalid=010 rdata=33", obs_rvalid, obs_rdata);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) smem[a] = init_val(a);
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
        reset = 1'b0;
        clear_inputs();
        cycle();
        reset = 1'b1;
        chk_en = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_rmw();
        test_lock_cap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
